serie_paralelo_sync: RTL and testbench

Parametrised serial-to-parallel receiver for the PHY RX path. It runs entirely on the serial bit clock and assembles MSB-first words of WIDTH bits. It acquires lock after LOCK_COUNT consecutive comma words, then delivers each payload word with a single-cycle valid strobe. Compared with the fixed 8-bit, dual-clock receiver, it adds width/comma/lock-count parameters, a per-word strobe, and loss-of-sync recovery before lock. Optional bit-offset comma hunting is available.

---
 rtl/serie_paralelo_sync.sv | 118 +++++++++++
 tb/tb_serie_paralelo_sync.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serie_paralelo_sync.sv
// Serial-to-parallel receiver: assembles MSB-first WIDTH-bit words on clk_8f, locks after LOCK_COUNT commas.
// Define SERIE_PARALELO_DESKEW_EN to hunt for the comma at any bit offset and realign the word boundary.
//
// state  | meaning
// HUNT   | searching for the first comma, not locked
// SYNC   | counting consecutive commas toward lock
// ACTIVE | locked, payload words delivered with valid_out
module serie_paralelo_sync #(
    parameter int              WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA     = 8'hBC,
    parameter int              LOCK_COUNT = 4,
    parameter int              CNT_W      = $clog2(LOCK_COUNT + 1)
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data2send,
    output logic             valid_out,
    output logic             word_stb,
    output logic             active,
    output logic [CNT_W-1:0] BC_counter
);

    localparam int               BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0]    LAST   = BW'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LOCK_V = CNT_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-2:0] sr;
    logic [BW-1:0]    bitcnt, bitcnt_nx;
    logic [WIDTH-1:0] cand, data_nx;
    logic             boundary, is_comma;
    logic             valid_nx, stb_nx, active_nx;
    logic [CNT_W-1:0] bc_nx;

    // The word completes with the bit being sampled on this edge.
    assign cand     = {sr, data_in};
    assign boundary = (bitcnt == LAST);
    assign is_comma = (cand == COMMA);

    always_comb begin
        state_nx  = state;
        bitcnt_nx = boundary ? '0 : bitcnt + 1'b1;
        data_nx   = data2send;
        valid_nx  = 1'b0;
        stb_nx    = boundary;
        bc_nx     = BC_counter;
        case (state)
            HUNT: begin
`ifdef SERIE_PARALELO_DESKEW_EN
                if (is_comma) begin
                    bitcnt_nx = '0;
                    bc_nx     = CNT_W'(1);
                    state_nx  = (LOCK_COUNT == 1) ? ACTIVE : SYNC;
                end
`else
                if (boundary && is_comma) begin
                    bc_nx    = CNT_W'(1);
                    state_nx = (LOCK_COUNT == 1) ? ACTIVE : SYNC;
                end
`endif
            end
            SYNC: begin
                if (boundary) begin
                    if (is_comma) begin
                        bc_nx = BC_counter + 1'b1;
                        if (bc_nx == LOCK_V) state_nx = ACTIVE;
                    end else begin
                        bc_nx    = '0;
                        state_nx = HUNT;
                    end
                end
            end
            ACTIVE: begin
                bc_nx = LOCK_V;
                if (boundary) begin
                    data_nx  = cand;
                    valid_nx = !is_comma;
                end
            end
            default: begin
                state_nx = HUNT;
                bc_nx    = '0;
            end
        endcase
        // Lock is sticky: ACTIVE has no exit other than reset.
        active_nx = (state_nx == ACTIVE);
    end

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state      <= HUNT;
            sr         <= '0;
            bitcnt     <= '0;
            data2send  <= '0;
            valid_out  <= 1'b0;
            word_stb   <= 1'b0;
            active     <= 1'b0;
            BC_counter <= '0;
        end else begin
            state      <= state_nx;
            sr         <= cand[WIDTH-2:0];
            bitcnt     <= bitcnt_nx;
            data2send  <= data_nx;
            valid_out  <= valid_nx;
            word_stb   <= stb_nx;
            active     <= active_nx;
            BC_counter <= bc_nx;
        end
    end

endmodule

// File: tb/tb_serie_paralelo_sync.sv
// Scoreboard bench for serie_paralelo_sync: default instance plus a WIDTH=10 / LOCK_COUNT=2 instance.
// Expected word-boundary records are queued by the stimulus and popped by per-instance monitors on word_stb.
module tb_serie_paralelo_sync;

    logic clk_8f = 1'b0;
    always #5 clk_8f = ~clk_8f;

    logic       reset_a = 1'b1, data_in_a = 1'b0;
    logic [7:0] data2send_a;
    logic       valid_out_a, word_stb_a, active_a;
    logic [2:0] BC_counter_a;

    logic       reset_b = 1'b1, data_in_b = 1'b0;
    logic [9:0] data2send_b;
    logic       valid_out_b, word_stb_b, active_b;
    logic [1:0] BC_counter_b;

    serie_paralelo_sync dut_a (
        .clk_8f    (clk_8f),
        .reset     (reset_a),
        .data_in   (data_in_a),
        .data2send (data2send_a),
        .valid_out (valid_out_a),
        .word_stb  (word_stb_a),
        .active    (active_a),
        .BC_counter(BC_counter_a)
    );

    serie_paralelo_sync #(
        .WIDTH     (10),
        .COMMA     (10'h17C),
        .LOCK_COUNT(2)
    ) dut_b (
        .clk_8f    (clk_8f),
        .reset     (reset_b),
        .data_in   (data_in_b),
        .data2send (data2send_b),
        .valid_out (valid_out_b),
        .word_stb  (word_stb_b),
        .active    (active_b),
        .BC_counter(BC_counter_b)
    );

    typedef struct {
        logic [15:0] data;
        logic        valid;
        logic [3:0]  bc;
        logic        act;
    } exp_t;

    exp_t  qa[$], qb[$];
    exp_t  ea, eb;
    int    n_cmp = 0, n_bad = 0;
    string tname = "init";

    function automatic exp_t mk(int d, bit v, int bc, bit a);
        exp_t e;
        e.data  = 16'(d);
        e.valid = v;
        e.bc    = 4'(bc);
        e.act   = a;
        return e;
    endfunction

    // Monitors: one record per word boundary.
    always @(negedge clk_8f) begin
        if (word_stb_a) begin
            n_cmp++;
            if (qa.size() == 0) begin
                n_bad++;
                $display("FAIL %s strobe_a: unexpected word_stb, data2send=%h valid=%b bc=%0d active=%b",
                         tname, data2send_a, valid_out_a, BC_counter_a, active_a);
            end else begin
                ea = qa.pop_front();
                if (data2send_a !== ea.data[7:0] || valid_out_a !== ea.valid ||
                    BC_counter_a !== ea.bc[2:0] || active_a !== ea.act) begin
                    n_bad++;
                    $display("FAIL %s word_a: got data=%h valid=%b bc=%0d act=%b, expected data=%h valid=%b bc=%0d act=%b",
                             tname, data2send_a, valid_out_a, BC_counter_a, active_a,
                             ea.data[7:0], ea.valid, ea.bc, ea.act);
                end
            end
        end
        if (valid_out_a && !word_stb_a) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s valid_a: valid_out=1 without word_stb (expected 0)", tname);
        end
    end

    always @(negedge clk_8f) begin
        if (word_stb_b) begin
            n_cmp++;
            if (qb.size() == 0) begin
                n_bad++;
                $display("FAIL %s strobe_b: unexpected word_stb, data2send=%h valid=%b bc=%0d active=%b",
                         tname, data2send_b, valid_out_b, BC_counter_b, active_b);
            end else begin
                eb = qb.pop_front();
                if (data2send_b !== eb.data[9:0] || valid_out_b !== eb.valid ||
                    BC_counter_b !== eb.bc[1:0] || active_b !== eb.act) begin
                    n_bad++;
                    $display("FAIL %s word_b: got data=%h valid=%b bc=%0d act=%b, expected data=%h valid=%b bc=%0d act=%b",
                             tname, data2send_b, valid_out_b, BC_counter_b, active_b,
                             eb.data[9:0], eb.valid, eb.bc, eb.act);
                end
            end
        end
        if (valid_out_b && !word_stb_b) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s valid_b: valid_out=1 without word_stb (expected 0)", tname);
        end
    end

    task automatic bit_a(input logic b);
        data_in_a = b;
        @(posedge clk_8f);
        #1;
    endtask

    task automatic word_a(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) bit_a(w[i]);
    endtask

    task automatic bit_b(input logic b);
        data_in_b = b;
        @(posedge clk_8f);
        #1;
    endtask

    task automatic word_b(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) bit_b(w[i]);
    endtask

    task automatic check_zero_a(input string nm);
        n_cmp++;
        if ({data2send_a, valid_out_a, word_stb_a, active_a, BC_counter_a} !== '0) begin
            n_bad++;
            $display("FAIL %s: outputs data=%h valid=%b stb=%b act=%b bc=%0d, expected all 0",
                     nm, data2send_a, valid_out_a, word_stb_a, active_a, BC_counter_a);
        end
    endtask

    task automatic reset_a_seq();
        reset_a = 1'b1;
        repeat (3) begin
            data_in_a = 1'($urandom_range(0, 1));
            @(posedge clk_8f);
            #1;
        end
        check_zero_a({tname, "_reset"});
        reset_a = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 4 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk_8f);
        #1;
        n_cmp++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_bad++;
            $display("FAIL %s drain: %0d/%0d records still pending, expected 0", nm, qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
        data_in_a = 1'b0;
        data_in_b = 1'b0;
    endtask

    initial begin
        #1;
        // Reset, then an idle line that never contains a comma.
        tname = "reset_idle";
        reset_a_seq();
        repeat (4) qa.push_back(mk(0, 0, 0, 0));
        repeat (32) bit_a(1'b0);
        drain(tname);
        n_cmp++;
        if (active_a !== 1'b0) begin
            n_bad++;
            $display("FAIL %s active: got %b, expected 0", tname, active_a);
        end

        tname = "aligned_lock";
        reset_a_seq();
        qa.push_back(mk(0, 0, 1, 0));
        qa.push_back(mk(0, 0, 2, 0));
        qa.push_back(mk(0, 0, 3, 0));
        qa.push_back(mk(0, 0, 4, 1));
        qa.push_back(mk(8'h5A, 1, 4, 1));
        qa.push_back(mk(8'hBC, 0, 4, 1));
        repeat (4) word_a(8'hBC);
        word_a(8'h5A);
        word_a(8'hBC);
        drain(tname);

        // Three junk bits put the commas off the reset-time word grid.
        tname = "deskew";
        reset_a_seq();
`ifdef SERIE_PARALELO_DESKEW_EN
        qa.push_back(mk(0, 0, 0, 0));
        qa.push_back(mk(0, 0, 2, 0));
        qa.push_back(mk(0, 0, 3, 0));
        qa.push_back(mk(0, 0, 4, 1));
        qa.push_back(mk(8'hBC, 0, 4, 1));
        qa.push_back(mk(8'h3C, 1, 4, 1));
`else
        repeat (6) qa.push_back(mk(0, 0, 0, 0));
`endif
        bit_a(1'b1);
        bit_a(1'b0);
        bit_a(1'b1);
        repeat (5) word_a(8'hBC);
        word_a(8'h3C);
        drain(tname);

        tname = "broken_sync";
        reset_a_seq();
        qa.push_back(mk(0, 0, 1, 0));
        qa.push_back(mk(0, 0, 2, 0));
        qa.push_back(mk(0, 0, 0, 0));
        qa.push_back(mk(0, 0, 1, 0));
        qa.push_back(mk(0, 0, 2, 0));
        qa.push_back(mk(0, 0, 3, 0));
        qa.push_back(mk(0, 0, 4, 1));
        word_a(8'hBC);
        word_a(8'hBC);
        word_a(8'h00);
        repeat (4) word_a(8'hBC);
        drain(tname);

        tname = "reset_mid";
        reset_a_seq();
        qa.push_back(mk(0, 0, 1, 0));
        qa.push_back(mk(0, 0, 2, 0));
        qa.push_back(mk(0, 0, 3, 0));
        qa.push_back(mk(0, 0, 4, 1));
        qa.push_back(mk(8'hA5, 1, 4, 1));
        repeat (4) word_a(8'hBC);
        word_a(8'hA5);
        bit_a(1'b1);
        bit_a(1'b1);
        bit_a(1'b0);
        reset_a   = 1'b1;
        data_in_a = 1'b0;
        @(posedge clk_8f);
        #1;
        check_zero_a("reset_mid_now");
        reset_a = 1'b0;
        qa.push_back(mk(0, 0, 1, 0));
        qa.push_back(mk(0, 0, 2, 0));
        qa.push_back(mk(0, 0, 3, 0));
        qa.push_back(mk(0, 0, 4, 1));
        qa.push_back(mk(8'hC3, 1, 4, 1));
        repeat (4) word_a(8'hBC);
        word_a(8'hC3);
        drain(tname);
        reset_a = 1'b1;

        tname = "width10";
        reset_b = 1'b1;
        repeat (3) begin
            data_in_b = 1'($urandom_range(0, 1));
            @(posedge clk_8f);
            #1;
        end
        n_cmp++;
        if ({data2send_b, valid_out_b, word_stb_b, active_b, BC_counter_b} !== '0) begin
            n_bad++;
            $display("FAIL width10_reset: outputs data=%h valid=%b stb=%b act=%b bc=%0d, expected all 0",
                     data2send_b, valid_out_b, word_stb_b, active_b, BC_counter_b);
        end
        reset_b = 1'b0;
        qb.push_back(mk(0, 0, 1, 0));
        qb.push_back(mk(0, 0, 2, 1));
        qb.push_back(mk(10'h2A5, 1, 2, 1));
        word_b(10'h17C);
        word_b(10'h17C);
        word_b(10'h2A5);
        drain(tname);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached in %s", tname);
        $fatal(1, "watchdog");
    end

endmodule
